booth_bist_mult: RTL and testbench
==================================

Name: booth_bist_mult

Overview:
- Parametrised sequential radix-2 Booth multiplier for signed operands, with an integrated BIST engine.
- Successor to the fixed 4-bit BIST multiplier; adds generic WIDTH, an LFSR pattern generator, a MISR signature, a configurable pattern count, a done pulse, a fail flag and abort handling.
- In functional mode it multiplies the a/b port operands on request.
- In test mode it self-drives NUM_PATTERNS pseudo-random operand pairs and compares the compacted signature against GOLDEN_SIG.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH; legal range 2..32.
- NUM_PATTERNS, 15, number of BIST multiplications per test run; must be ≥1.
- LFSR_SEED, 8'h01, 2*WIDTH-bit LFSR seed; must be nonzero.
- LFSR_TAPS, 8'hB8, 2*WIDTH-bit Galois LFSR feedback mask.
- MISR_TAPS, 8'hB8, 2*WIDTH-bit Galois MISR feedback mask.
- GOLDEN_SIG, 8'h00, expected final MISR value for this parameter set; computed by the bench reference model.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a  in  WIDTH  signed multiplicand, functional mode.
- b  in  WIDTH  signed multiplier, functional mode.
- start  in  1  functional multiply request, level-sampled in IDLE.
- test  in  1  BIST enable, level-sensitive.
- product  out  2*WIDTH  signed product register.
- done  out  1  one-cycle pulse when product updates.
- busy  out  1  high while a multiply or BIST run is in progress.
- pass  out  1  BIST signature matched.
- fail  out  1  BIST signature mismatched.

Behaviour:
- Reset (async, rst_n=0):
  - product=0, done=0, busy=0, pass=0, fail=0.
  - FSM=IDLE, LFSR=LFSR_SEED, MISR=0, iteration and pattern counters=0.
- FSM states: IDLE, MUL, B_LOAD, B_MUL, B_CMP, B_HOLD.
- IDLE:
  - test=1 → B_LOAD. test has priority over start when both are high.
  - else start=1 → latch a and b, clear accumulator and Q(-1) → MUL; busy=1 from this edge.
- MUL:
  - Each cycle examines Q[0],Q(-1): 01 adds M, 10 subtracts M, 00/11 no-op. Then arithmetic right shift of {A,Q,Q(-1)}.
  - Runs exactly WIDTH cycles.
  - On the WIDTH-th MUL edge: product<={A,Q}, done=1 for one cycle, busy=0, → IDLE.
  - Latency: product/done valid WIDTH edges after the accepting edge. A new start can be accepted on the edge after done.
  - start, a and b are ignored while busy.
  - Most-negative operands are exact, e.g. (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
- B_LOAD:
  - On entry from IDLE: LFSR=LFSR_SEED, MISR=0, pattern count=0, pass=fail=0, busy=1.
  - Each pass loads operands a=LFSR[2W-1:W], b=LFSR[W-1:0] → B_MUL.
- B_MUL:
  - Same Booth core, WIDTH cycles.
  - On completion: product updates, done pulses, MISR<=Galois_shift(MISR)^product, LFSR advances one Galois step, count++.
  - count==NUM_PATTERNS → B_CMP; else → B_LOAD.
- B_CMP: one cycle. pass=(MISR==GOLDEN_SIG), fail=~pass, busy=0 → B_HOLD.
- Galois step for both LFSR and MISR: x>>1 ^ (x[0] ? TAPS : 0).
- B_HOLD:
  - pass/fail held while test=1.
  - On test=0 → IDLE; pass/fail remain until the next BIST start or reset.
- Abort: test dropping during B_LOAD/B_MUL/B_CMP → IDLE next edge, busy=0, pass=fail=0, no done for the aborted pattern.
- Reset asserted mid-operation: immediate return to reset values; no partial product is emitted.
- pass and fail are never both 1.

Optional Feature:
- BIST_SIG_OUT_EN defined:
  - Adds output port signature [2*WIDTH-1:0] carrying the live MISR value; reset 0.
  - Also adds a one-cycle sig_valid output asserted in B_CMP.
- BIST_SIG_OUT_EN undefined: both ports are absent, the MISR is internal only, and behaviour is otherwise identical.

Test Plan:
- Reset mid-MUL: a=3, b=2, start; assert rst_n=0 two cycles later → all outputs 0 asynchronously, FSM IDLE, no done.
- WIDTH=4, a=-3 (4'hD), b=5, start one cycle:
  - busy high 4 cycles.
  - On the 4th edge: product=8'hF1, done=1 for one cycle.
- WIDTH=4 corners:
  - a=-8, b=-8 → 8'h40.
  - a=7, b=7 → 8'h31.
  - a=0, b=-1 → 8'h00.
  - Back-to-back starts accepted on the edge after each done.
- test=1 with GOLDEN_SIG taken from the model for 15 patterns:
  - 15 done pulses, each product matching the model.
  - pass=1, fail=0 after B_CMP; held until test=0.
- Same run with GOLDEN_SIG XOR 8'h01 → fail=1, pass=0.
- test dropped during pattern 7 → next edge IDLE, busy=0, pass=fail=0.
- start and test asserted together in IDLE → BIST runs and start is ignored.

Source files
------------

// File: rtl/booth_bist_mult.sv
// Sequential radix-2 Booth signed multiplier with an LFSR/MISR built-in self test.
// Optional macro BIST_SIG_OUT_EN exposes the live MISR value (signature) and a sig_valid strobe.
module booth_bist_mult #(
  parameter int                 WIDTH        = 4,
  parameter int                 NUM_PATTERNS = 15,
  parameter logic [2*WIDTH-1:0] LFSR_SEED    = 8'h01,
  parameter logic [2*WIDTH-1:0] LFSR_TAPS    = 8'hB8,
  parameter logic [2*WIDTH-1:0] MISR_TAPS    = 8'hB8,
  parameter logic [2*WIDTH-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  input  logic                 test,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [2*WIDTH-1:0]   signature,
  output logic                 sig_valid
`endif
);

  localparam int P  = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (NUM_PATTERNS < 2) ? 1 : $clog2(NUM_PATTERNS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL    = 3'd1,
    B_LOAD = 3'd2,
    B_MUL  = 3'd3,
    B_CMP  = 3'd4,
    B_HOLD = 3'd5
  } state_t;

  function automatic logic [P-1:0] galois_step(input logic [P-1:0] x, input logic [P-1:0] taps);
    return (x >> 1'b1) ^ (x[0] ? taps : {P{1'b0}});
  endfunction

  state_t            state_r, state_s;
  logic [WIDTH:0]    acc_r;
  logic [WIDTH-1:0]  q_r;
  logic [WIDTH-1:0]  m_r;
  logic              qm1_r;
  logic [CW-1:0]     cnt_r;
  logic [PW-1:0]     pcnt_r;
  logic [P-1:0]      lfsr_r;
  logic [P-1:0]      misr_r;
  logic [P-1:0]      product_r;
  logic              done_r;
  logic              busy_r;
  logic              pass_r;
  logic              fail_r;
  logic              sig_valid_r;

  logic [WIDTH:0]    m_ext_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH:0]    acc_nxt_s;
  logic [WIDTH-1:0]  q_nxt_s;
  logic [P-1:0]      prod_s;
  logic              last_s;
  logic [PW-1:0]     pcnt_inc_s;

  // Booth step: one extra accumulator bit keeps the most-negative multiplicand exact.
  always_comb begin
    m_ext_s = {m_r[WIDTH-1], m_r};
    case ({q_r[0], qm1_r})
      2'b01:   sum_s = acc_r + m_ext_s;
      2'b10:   sum_s = acc_r - m_ext_s;
      default: sum_s = acc_r;
    endcase
    acc_nxt_s  = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_nxt_s    = {sum_s[0], q_r[WIDTH-1:1]};
    prod_s     = {acc_nxt_s[WIDTH-1:0], q_nxt_s};
    last_s     = (cnt_r == CW'(WIDTH - 1));
    pcnt_inc_s = pcnt_r + 1'b1;
  end

  // Next-state logic; dropping test aborts any BIST state back to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (test) begin
          state_s = B_LOAD;
        end else if (start) begin
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (last_s) state_s = IDLE;
        else        state_s = MUL;
      end
      B_LOAD: begin
        if (!test) state_s = IDLE;
        else       state_s = B_MUL;
      end
      B_MUL: begin
        if (!test) begin
          state_s = IDLE;
        end else if (last_s) begin
          if (pcnt_inc_s == PW'(NUM_PATTERNS)) state_s = B_CMP;
          else                                  state_s = B_LOAD;
        end else begin
          state_s = B_MUL;
        end
      end
      B_CMP: begin
        if (!test) state_s = IDLE;
        else       state_s = B_HOLD;
      end
      B_HOLD: begin
        if (!test) state_s = IDLE;
        else       state_s = B_HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath, BIST compaction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      q_r         <= '0;
      m_r         <= '0;
      qm1_r       <= 1'b0;
      cnt_r       <= '0;
      pcnt_r      <= '0;
      lfsr_r      <= LFSR_SEED;
      misr_r      <= '0;
      product_r   <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      sig_valid_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      sig_valid_r <= (state_s == B_CMP);
      case (state_r)
        IDLE: begin
          if (test) begin
            lfsr_r <= LFSR_SEED;
            misr_r <= '0;
            pcnt_r <= '0;
            pass_r <= 1'b0;
            fail_r <= 1'b0;
            busy_r <= 1'b1;
          end else if (start) begin
            m_r    <= a;
            q_r    <= b;
            acc_r  <= '0;
            qm1_r  <= 1'b0;
            cnt_r  <= '0;
            busy_r <= 1'b1;
          end
        end
        MUL: begin
          acc_r <= acc_nxt_s;
          q_r   <= q_nxt_s;
          qm1_r <= q_r[0];
          cnt_r <= cnt_r + 1'b1;
          if (last_s) begin
            product_r <= prod_s;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        B_LOAD: begin
          if (!test) begin
            busy_r <= 1'b0;
            pass_r <= 1'b0;
            fail_r <= 1'b0;
          end else begin
            m_r   <= lfsr_r[P-1:WIDTH];
            q_r   <= lfsr_r[WIDTH-1:0];
            acc_r <= '0;
            qm1_r <= 1'b0;
            cnt_r <= '0;
          end
        end
        B_MUL: begin
          if (!test) begin
            busy_r <= 1'b0;
            pass_r <= 1'b0;
            fail_r <= 1'b0;
          end else begin
            acc_r <= acc_nxt_s;
            q_r   <= q_nxt_s;
            qm1_r <= q_r[0];
            cnt_r <= cnt_r + 1'b1;
            if (last_s) begin
              product_r <= prod_s;
              done_r    <= 1'b1;
              misr_r    <= galois_step(misr_r, MISR_TAPS) ^ prod_s;
              lfsr_r    <= galois_step(lfsr_r, LFSR_TAPS);
              pcnt_r    <= pcnt_inc_s;
            end
          end
        end
        B_CMP: begin
          busy_r <= 1'b0;
          if (!test) begin
            pass_r <= 1'b0;
            fail_r <= 1'b0;
          end else begin
            pass_r <= (misr_r == GOLDEN_SIG);
            fail_r <= (misr_r != GOLDEN_SIG);
          end
        end
        B_HOLD: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_r;
  assign done    = done_r;
  assign busy    = busy_r;
  assign pass    = pass_r;
  assign fail    = fail_r;

`ifdef BIST_SIG_OUT_EN
  assign signature = misr_r;
  assign sig_valid = sig_valid_r;
`endif

endmodule

// File: tb/tb_booth_bist_mult.sv
// Directed self-checking bench for booth_bist_mult (WIDTH=4, 15 BIST patterns).
// Two instances share stimulus: one with the model golden signature, one with it corrupted.
module tb_booth_bist_mult;

  localparam int         W    = 4;
  localparam int         NP   = 15;
  localparam logic [7:0] SEED = 8'h01;
  localparam logic [7:0] LT   = 8'hB8;
  localparam logic [7:0] MT   = 8'hB8;

  function automatic logic [7:0] gstep(input logic [7:0] x, input logic [7:0] t);
    return (x >> 1) ^ (x[0] ? t : 8'h00);
  endfunction

  function automatic logic [7:0] pat_prod(input logic [7:0] l);
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    ea = {{4{l[7]}}, l[7:4]};
    eb = {{4{l[3]}}, l[3:0]};
    return ea * eb;
  endfunction

  function automatic logic [7:0] model_sig();
    logic [7:0] l;
    logic [7:0] m;
    l = SEED;
    m = 8'h00;
    for (int k = 0; k < NP; k++) begin
      m = gstep(m, MT) ^ pat_prod(l);
      l = gstep(l, LT);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD = model_sig();

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       start, test;
  logic [7:0] product_g, product_b;
  logic       done_g, busy_g, pass_g, fail_g;
  logic       done_b, busy_b, pass_b, fail_b;
`ifdef BIST_SIG_OUT_EN
  logic [7:0] sig_g, sig_b;
  logic       sv_g, sv_b;
`endif

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_prod [NP];

  always #5 clk = ~clk;

  booth_bist_mult #(.WIDTH(W), .NUM_PATTERNS(NP), .LFSR_SEED(SEED), .LFSR_TAPS(LT),
                    .MISR_TAPS(MT), .GOLDEN_SIG(GOLD)) dut_g (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start), .test(test),
    .product(product_g), .done(done_g), .busy(busy_g), .pass(pass_g), .fail(fail_g)
`ifdef BIST_SIG_OUT_EN
    , .signature(sig_g), .sig_valid(sv_g)
`endif
  );

  booth_bist_mult #(.WIDTH(W), .NUM_PATTERNS(NP), .LFSR_SEED(SEED), .LFSR_TAPS(LT),
                    .MISR_TAPS(MT), .GOLDEN_SIG(GOLD ^ 8'h01)) dut_b (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start), .test(test),
    .product(product_b), .done(done_b), .busy(busy_b), .pass(pass_b), .fail(fail_b)
`ifdef BIST_SIG_OUT_EN
    , .signature(sig_b), .sig_valid(sv_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; test = 1'b0; a = 4'h0; b = 4'h0;
    tick(); tick();
    n_total++;
    if ({product_g, done_g, busy_g, pass_g, fail_g} !== 12'h000)
      $display("FAIL reset_state: got prod=%h done=%b busy=%b pass=%b fail=%b, want all 0",
               product_g, done_g, busy_g, pass_g, fail_g);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] exp,
                          input string name);
    logic ok;
    a = ta; b = tb; start = 1'b1;
    tick();
    start = 1'b0; a = 4'h5; b = 4'h5;
    n_total++;
    if (busy_g !== 1'b1 || done_g !== 1'b0)
      $display("FAIL %s_accept: got busy=%b done=%b, want busy=1 done=0", name, busy_g, done_g);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < W - 1; i++) begin
      tick();
      if (busy_g !== 1'b1 || done_g !== 1'b0) ok = 1'b0;
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL %s_busy_window: busy dropped or done early", name);
    else n_pass++;
    tick();
    n_total++;
    if (product_g !== exp || done_g !== 1'b1 || busy_g !== 1'b0)
      $display("FAIL %s_result: got prod=%h done=%b busy=%b, want prod=%h done=1 busy=0",
               name, product_g, done_g, busy_g, exp);
    else n_pass++;
    tick();
    n_total++;
    if (done_g !== 1'b0 || product_g !== exp)
      $display("FAIL %s_done_pulse: got done=%b prod=%h, want done=0 prod=%h",
               name, done_g, product_g, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    a = 4'h2; b = 4'h3; start = 1'b1;
    tick();
    a = 4'hE; b = 4'h3;
    repeat (W) tick();
    n_total++;
    if (done_g !== 1'b1 || product_g !== 8'h06)
      $display("FAIL b2b_first: got done=%b prod=%h, want done=1 prod=06", done_g, product_g);
    else n_pass++;
    tick();
    n_total++;
    if (busy_g !== 1'b1 || done_g !== 1'b0)
      $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy_g, done_g);
    else n_pass++;
    repeat (W) tick();
    n_total++;
    if (done_g !== 1'b1 || product_g !== 8'hFA)
      $display("FAIL b2b_second: got done=%b prod=%h, want done=1 prod=fa", done_g, product_g);
    else n_pass++;
    start = 1'b0;
    tick();
    n_total++;
    if (done_g !== 1'b0 || busy_g !== 1'b0)
      $display("FAIL b2b_idle: got done=%b busy=%b, want 0 0", done_g, busy_g);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    a = 4'h3; b = 4'h2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({product_g, done_g, busy_g, pass_g, fail_g} !== 12'h000)
      $display("FAIL reset_mid_mul: got prod=%h done=%b busy=%b, want all 0",
               product_g, done_g, busy_g);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (done_g !== 1'b0 || busy_g !== 1'b0 || product_g !== 8'h00) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL reset_no_partial: got activity after reset, want none");
    else n_pass++;
  endtask

  task automatic test_bist();
    int k;
    int cyc;
    a = 4'h7; b = 4'h7; start = 1'b1; test = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy_g !== 1'b1 || pass_g !== 1'b0 || fail_g !== 1'b0)
      $display("FAIL bist_start: got busy=%b pass=%b fail=%b, want 1 0 0", busy_g, pass_g, fail_g);
    else n_pass++;
    k = 0;
    cyc = 0;
    while (k < NP && cyc < 200) begin
      tick();
      cyc++;
      if (done_g === 1'b1) begin
        n_total++;
        if (product_g !== exp_prod[k] || product_b !== exp_prod[k])
          $display("FAIL bist_pattern_%0d: got prod=%h/%h, want %h",
                   k, product_g, product_b, exp_prod[k]);
        else n_pass++;
        k++;
      end
    end
    n_total++;
    if (k !== NP) $display("FAIL bist_done_count: got %0d done pulses, want %0d", k, NP);
    else n_pass++;
    tick();
    n_total++;
    if ({pass_g, fail_g, busy_g, done_g} !== 4'b1000)
      $display("FAIL bist_pass: got pass=%b fail=%b busy=%b done=%b, want 1 0 0 0",
               pass_g, fail_g, busy_g, done_g);
    else n_pass++;
    n_total++;
    if ({pass_b, fail_b} !== 2'b01)
      $display("FAIL bist_bad_golden: got pass=%b fail=%b, want 0 1", pass_b, fail_b);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if ({pass_g, fail_g, pass_b, fail_b, done_g} !== 5'b10010)
      $display("FAIL bist_hold: got g=%b%b b=%b%b done=%b, want g=10 b=01 done=0",
               pass_g, fail_g, pass_b, fail_b, done_g);
    else n_pass++;
    test = 1'b0;
    tick(); tick();
    n_total++;
    if ({pass_g, fail_g, pass_b, fail_b, busy_g} !== 5'b10010)
      $display("FAIL bist_after_release: got g=%b%b b=%b%b busy=%b, want g=10 b=01 busy=0",
               pass_g, fail_g, pass_b, fail_b, busy_g);
    else n_pass++;
  endtask

  task automatic test_bist_abort();
    int k;
    int cyc;
    logic seen;
    test = 1'b1;
    tick();
    n_total++;
    if (pass_g !== 1'b0 || fail_b !== 1'b0)
      $display("FAIL abort_clear_flags: got pass_g=%b fail_b=%b, want 0 0", pass_g, fail_b);
    else n_pass++;
    k = 0;
    cyc = 0;
    while (k < 6 && cyc < 200) begin
      tick();
      cyc++;
      if (done_g === 1'b1) k++;
    end
    n_total++;
    if (k !== 6) $display("FAIL abort_reach_p7: got %0d done pulses, want 6", k);
    else n_pass++;
    tick(); tick();
    test = 1'b0;
    tick();
    n_total++;
    if ({busy_g, pass_g, fail_g, done_g, busy_b, pass_b, fail_b, done_b} !== 8'h00)
      $display("FAIL abort_state: got g busy/pass/fail/done=%b%b%b%b b=%b%b%b%b, want all 0",
               busy_g, pass_g, fail_g, done_g, busy_b, pass_b, fail_b, done_b);
    else n_pass++;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (done_g !== 1'b0 || busy_g !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL abort_no_done: got done/busy after abort, want none");
    else n_pass++;
  endtask

  initial begin
    logic [7:0] l;
    l = SEED;
    for (int k = 0; k < NP; k++) begin
      exp_prod[k] = pat_prod(l);
      l = gstep(l, LT);
    end
    test_reset();
    test_mul(4'hD, 4'h5, 8'hF1, "mul_m3x5");
    test_mul(4'h8, 4'h8, 8'h40, "mul_m8xm8");
    test_mul(4'h7, 4'h7, 8'h31, "mul_7x7");
    test_mul(4'h0, 4'hF, 8'h00, "mul_0xm1");
    test_back_to_back();
    test_reset_mid_mul();
    test_bist();
    test_bist_abort();
    test_mul(4'h3, 4'h2, 8'h06, "mul_after_abort");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
